// File: rtl/slave_fifo2b_stream_out.sv
// FX3 slave-FIFO stream-OUT reader: strobes the FX3 read interface while buffer space allows,
// captures words READ_LATENCY cycles after each strobe and presents them as a ready/valid stream.
module slave_fifo2b_stream_out #(
    parameter int DEPTH        = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_100,
    input  logic        reset_,
    input  logic        stream_out_mode_selected,
    input  logic        flagc_d,
    input  logic        flagd_d,
    input  logic [31:0] data_in,
    input  logic        out_ready,
    output logic        sloe_streamOUT_,
    output logic        slrd_streamOUT_,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        reading,
    output logic [31:0] words_received,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    // Wide enough to hold count + inflight without wrapping.
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OE_SETUP = 2'd1,
        ST_READ     = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic                    sloe_r, reading_r, overflow_r;
    logic [READ_LATENCY-1:0] sr_r, sr_nxt_s;
    logic [CW-1:0]           count_r, inflight_s, used_s;
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [31:0]             mem_r [DEPTH];
    logic [31:0]             words_r;
    logic                    strobe_s, capture_s, push_s, pop_s, full_s;

    function automatic logic [CW-1:0] popcount(input logic [READ_LATENCY-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            n = n + {{(CW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Strobe qualification, capture/push/pop decisions and next state.
    always_comb begin
        inflight_s = popcount(sr_r);
        used_s     = count_r + inflight_s;
        strobe_s   = (state_r == ST_READ) && flagd_d && stream_out_mode_selected && (used_s < DEPTH_C);
        capture_s  = sr_r[READ_LATENCY-1];
        pop_s      = (count_r != '0) && out_ready;
        full_s     = (count_r == DEPTH_C);
        push_s     = capture_s && (!full_s || pop_s);
        sr_nxt_s    = sr_r << 1;
        sr_nxt_s[0] = strobe_s;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (stream_out_mode_selected && flagc_d) state_nxt_s = ST_OE_SETUP;
                else                                     state_nxt_s = ST_IDLE;
            end
            ST_OE_SETUP: state_nxt_s = ST_READ;
            ST_READ: begin
                if (!flagd_d || !stream_out_mode_selected) state_nxt_s = ST_DRAIN;
                else                                       state_nxt_s = ST_READ;
            end
            ST_DRAIN: begin
                if (inflight_s == '0) state_nxt_s = ST_IDLE;
                else                  state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM with registered interface enables.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state_r   <= ST_IDLE;
            sloe_r    <= 1'b1;
            reading_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            sloe_r    <= (state_nxt_s == ST_IDLE);
            reading_r <= (state_nxt_s == ST_READ);
        end
    end

    // In-flight tracking, buffer bookkeeping, word counter and sticky overflow.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            sr_r       <= '0;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            words_r    <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            sr_r <= sr_nxt_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            if (state_r == ST_IDLE && !stream_out_mode_selected) words_r <= 32'd0;
            else if (capture_s)                                  words_r <= words_r + 32'd1;
            if (capture_s && full_s && !pop_s) overflow_r <= 1'b1;
        end
    end

    // Buffer storage; contents are don't-care until counted valid.
    always_ff @(posedge clk_100) begin
        if (push_s) mem_r[wr_ptr_r] <= data_in;
    end

    assign sloe_streamOUT_ = sloe_r;
    assign slrd_streamOUT_ = ~strobe_s;
    assign reading         = reading_r;
    assign out_valid       = (count_r != '0);
    assign out_data        = mem_r[rd_ptr_r];
    assign words_received  = words_r;
    assign overflow        = overflow_r;

endmodule

// File: tb/tb_slave_fifo2b_stream_out.sv
// Directed bench for slave_fifo2b_stream_out with a queue-based reference model
// checked on every falling edge, plus hand-computed literal expectations.
module tb_slave_fifo2b_stream_out;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic        clk_100 = 1'b0;
    logic        reset_  = 1'b0;
    logic        mode    = 1'b0;
    logic        flagc   = 1'b0;
    logic        flagd   = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        out_ready = 1'b1;
    logic        sloe, slrd, out_valid, reading, overflow;
    logic [31:0] out_data, words_received;

    slave_fifo2b_stream_out #(.DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk_100(clk_100), .reset_(reset_), .stream_out_mode_selected(mode),
        .flagc_d(flagc), .flagd_d(flagd), .data_in(data_in), .out_ready(out_ready),
        .sloe_streamOUT_(sloe), .slrd_streamOUT_(slrd), .out_data(out_data),
        .out_valid(out_valid), .reading(reading), .words_received(words_received),
        .overflow(overflow)
    );

    always #5 clk_100 = ~clk_100;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int strobes = 0;
    bit cmp_en = 1'b0;

    // Reference model: phase 0 idle, 1 oe setup, 2 read, 3 drain.
    int          m_phase = 0;
    logic [31:0] m_buf[$];
    int          m_infl[$];
    logic [31:0] m_deliv[$];
    logic [31:0] m_words = 32'd0;
    bit          m_ovf = 1'b0;

    function automatic bit m_strobe();
        return (m_phase == 2) && flagd && mode && ((m_buf.size() + m_infl.size()) < DEPTH);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_100) begin
        cyc++;
        if (reset_ === 1'b1) begin
            bit st, cap, pp;
            int nxt;
            st  = m_strobe();
            pp  = (m_buf.size() != 0) && out_ready;
            cap = (m_infl.size() != 0) && (m_infl[0] == 1);
            nxt = m_phase;
            case (m_phase)
                0: if (mode && flagc) nxt = 1;
                1: nxt = 2;
                2: if (!flagd || !mode) nxt = 3;
                3: if (m_infl.size() == 0) nxt = 0;
                default: nxt = 0;
            endcase
            if (pp) m_deliv.push_back(m_buf.pop_front());
            if (cap) begin
                void'(m_infl.pop_front());
                if (m_buf.size() < DEPTH) m_buf.push_back(data_in);
                else m_ovf = 1'b1;
            end
            if (m_phase == 0 && !mode) m_words = 32'd0;
            else if (cap) m_words = m_words + 32'd1;
            foreach (m_infl[i]) m_infl[i] = m_infl[i] - 1;
            if (st) m_infl.push_back(LAT);
            m_phase = nxt;
        end
    end

    always @(negedge reset_) begin
        m_phase = 0;
        m_buf.delete();
        m_infl.delete();
        m_words = 32'd0;
        m_ovf = 1'b0;
    end

    // FX3 emulation: the bus carries the cycle index.
    always @(posedge clk_100) begin
        #1;
        data_in = cyc;
    end

    always @(negedge clk_100) begin
        if (reset_ === 1'b1 && cmp_en) begin
            chk1("sloe", sloe, m_phase == 0);
            chk1("slrd", slrd, !m_strobe());
            chk1("reading", reading, m_phase == 2);
            chk1("out_valid", out_valid, m_buf.size() != 0);
            if (m_buf.size() != 0) chk32("out_data", out_data, m_buf[0]);
            chk32("words_received", words_received, m_words);
            chk1("overflow", overflow, m_ovf);
            if (slrd === 1'b0) strobes++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(sloe === 1'b1 && out_valid === 1'b0) && n < 60) begin
            step(1);
            n++;
        end
        chk1(tag, n < 60, 1'b1);
    endtask

    initial begin
        logic [31:0] w0;
        int n;
        step(2);
        chk1("rst_sloe", sloe, 1'b1);
        chk1("rst_slrd", slrd, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_reading", reading, 1'b0);
        chk32("rst_words", words_received, 32'd0);
        chk1("rst_overflow", overflow, 1'b0);
        reset_ = 1'b1;
        cmp_en = 1'b1;

        // Six-strobe burst with a free-running consumer.
        mode = 1'b1; out_ready = 1'b1; flagc = 1'b1; flagd = 1'b1;
        strobes = 0; m_deliv.delete();
        step(8);
        flagd = 1'b0; flagc = 1'b0;
        wait_idle("t1_idle");
        chk32("t1_strobes", strobes, 32'd6);
        chk32("t1_words", words_received, 32'd6);
        chk32("t1_ndeliv", m_deliv.size(), 32'd6);
        for (int i = 1; i < m_deliv.size(); i++) chk32("t1_order", m_deliv[i], m_deliv[0] + i);

        // Stalled consumer: strobes stop once the buffer is fully committed.
        out_ready = 1'b0; flagc = 1'b1; flagd = 1'b1; strobes = 0;
        step(20);
        chk32("t2_strobes", strobes, 32'd8);
        chk32("t2_model_count", m_buf.size(), 32'd8);
        chk1("t2_out_valid", out_valid, 1'b1);
        chk1("t2_overflow", overflow, 1'b0);
        chk1("t2_slrd_held", slrd, 1'b1);
        strobes = 0; out_ready = 1'b1;
        step(6);
        chk1("t2_resume", strobes != 0, 1'b1);
        flagd = 1'b0; flagc = 1'b0;
        wait_idle("t2_idle");

        // Watermark drops mid-burst: strobe stops at once, two words drain.
        w0 = words_received; strobes = 0;
        flagc = 1'b1; flagd = 1'b1;
        step(5);
        flagd = 1'b0; flagc = 1'b0;
        #1;
        chk1("t3_slrd_same_cycle", slrd, 1'b1);
        chk1("t3_sloe_low", sloe, 1'b0);
        wait_idle("t3_idle");
        chk32("t3_words", words_received, w0 + 32'd3);
        chk1("t3_sloe_idle", sloe, 1'b1);

        // Mode dropped in READ: no new strobe, pending words still delivered, counter clears.
        flagc = 1'b1; flagd = 1'b1; strobes = 0;
        step(4);
        mode = 1'b0; flagc = 1'b0;
        #1;
        chk1("t4_slrd_stop", slrd, 1'b1);
        wait_idle("t4_idle");
        step(2);
        chk32("t4_strobes", strobes, 32'd2);
        chk32("t4_words_clear", words_received, 32'd0);
        flagd = 1'b0;

        // Counter wrap from all-ones on a single capture.
        mode = 1'b1;
        step(1);
        force dut.words_r = 32'hFFFF_FFFF;
        m_words = 32'hFFFF_FFFF;
        #2;
        release dut.words_r;
        flagc = 1'b1; flagd = 1'b1;
        step(3);
        flagd = 1'b0; flagc = 1'b0;
        wait_idle("t5_idle");
        chk32("t5_wrap", words_received, 32'd0);

        // Asynchronous reset while reading with three words buffered.
        out_ready = 1'b0; flagc = 1'b1; flagd = 1'b1;
        n = 0;
        while (m_buf.size() != 3 && n < 30) begin
            step(1);
            n++;
        end
        chk1("t6_fill", n < 30, 1'b1);
        chk1("t6_reading", reading, 1'b1);
        #1;
        reset_ = 1'b0; flagc = 1'b0; flagd = 1'b0;
        #1;
        chk1("t6_sloe", sloe, 1'b1);
        chk1("t6_slrd", slrd, 1'b1);
        chk1("t6_out_valid", out_valid, 1'b0);
        chk1("t6_reading_rst", reading, 1'b0);
        chk32("t6_words", words_received, 32'd0);
        chk1("t6_overflow", overflow, 1'b0);
        #1;
        reset_ = 1'b1;
        step(4);
        chk1("t6_out_valid_after", out_valid, 1'b0);
        chk1("t6_slrd_after", slrd, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
